// File: rtl/fpu_arbiter_if.sv
// Request, response and FPU-side signals of the two-requester FPU arbiter.
// rsp_exc exists only when FPU_ARB_EXC_EN is defined.
interface fpu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_op;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        busy;
`ifdef FPU_ARB_EXC_EN
  logic [1:0]  rsp_exc;
`endif

  modport slave (
`ifdef FPU_ARB_EXC_EN
    output rsp_exc,
`endif
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, fpu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, fpu_a, fpu_b, fpu_op, busy
  );

  modport master (
`ifdef FPU_ARB_EXC_EN
    input  rsp_exc,
`endif
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, fpu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, fpu_a, fpu_b, fpu_op, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one combinational FPU between two requesters, one op in flight.
// Optional NaN/Inf flags on the response are enabled by defining FPU_ARB_EXC_EN.
module fpu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fpu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        last_grant_reg, last_grant_next;
  logic        owner_reg, owner_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] fpu_a_reg, fpu_a_next;
  logic [31:0] fpu_b_reg, fpu_b_next;
  logic [1:0]  fpu_op_reg, fpu_op_next;
  logic [31:0] result_reg, result_next;
`ifdef FPU_ARB_EXC_EN
  logic [1:0]  exc_reg, exc_next;
`endif
  logic        grant_valid;
  logic        grant_id;
  logic        rsp_taken;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_reg;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign rsp_taken = owner_reg ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    cnt_next        = cnt_reg;
    fpu_a_next      = fpu_a_reg;
    fpu_b_next      = fpu_b_reg;
    fpu_op_next     = fpu_op_reg;
    result_next     = result_reg;
`ifdef FPU_ARB_EXC_EN
    exc_next        = exc_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next      = grant_id;
          last_grant_next = grant_id;
          cnt_next        = CNT_LOAD;
          state_next      = ISSUE;
          if (grant_id) begin
            fpu_a_next  = bus.req1_a;
            fpu_b_next  = bus.req1_b;
            fpu_op_next = bus.req1_op;
          end else begin
            fpu_a_next  = bus.req0_a;
            fpu_b_next  = bus.req0_b;
            fpu_op_next = bus.req0_op;
          end
        end
      end
      ISSUE: begin
        if (cnt_reg == 4'd0) begin
          result_next = bus.fpu_result;
`ifdef FPU_ARB_EXC_EN
          exc_next[0] = (bus.fpu_result[30:23] == 8'hFF) && (bus.fpu_result[22:0] != 23'd0);
          exc_next[1] = (bus.fpu_result[30:23] == 8'hFF) && (bus.fpu_result[22:0] == 23'd0);
`endif
          state_next  = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_taken) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cnt_reg        <= 4'd0;
      fpu_a_reg      <= 32'd0;
      fpu_b_reg      <= 32'd0;
      fpu_op_reg     <= 2'b00;
      result_reg     <= 32'd0;
`ifdef FPU_ARB_EXC_EN
      exc_reg        <= 2'b00;
`endif
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      cnt_reg        <= cnt_next;
      fpu_a_reg      <= fpu_a_next;
      fpu_b_reg      <= fpu_b_next;
      fpu_op_reg     <= fpu_op_next;
      result_reg     <= result_next;
`ifdef FPU_ARB_EXC_EN
      exc_reg        <= exc_next;
`endif
    end
  end

  assign bus.req0_ready = (state_reg == IDLE) && grant_valid && !grant_id;
  assign bus.req1_ready = (state_reg == IDLE) && grant_valid && grant_id;
  assign bus.rsp0_valid = (state_reg == RESP) && !owner_reg;
  assign bus.rsp1_valid = (state_reg == RESP) && owner_reg;
  assign bus.rsp_result = result_reg;
  assign bus.fpu_a      = fpu_a_reg;
  assign bus.fpu_b      = fpu_b_reg;
  assign bus.fpu_op     = fpu_op_reg;
  assign bus.busy       = (state_reg != IDLE);
`ifdef FPU_ARB_EXC_EN
  assign bus.rsp_exc    = exc_reg;
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: SETTLE_CYCLES=2 instance fully checked, SETTLE_CYCLES=1 for timing.
// Exception-flag vectors run only when FPU_ARB_EXC_EN is defined.
module tb_fpu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_arbiter_if bus ();
  fpu_arbiter_if bus1 ();

  fpu_arbiter #(.SETTLE_CYCLES(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  fpu_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Stand-in FPU: hand-computed results for the vectors used here.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'b00) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h40000000 && op == 2'b10) return 32'h40C00000;
    if (a == 32'h40000000 && b == 32'h40000000 && op == 2'b00) return 32'h40800000;
    if (a == 32'h3F800000 && b == 32'h3F800000 && op == 2'b01) return 32'h00000000;
    if (a == 32'h3F800000 && b == 32'h00000000 && op == 2'b11) return 32'h7F800000;
    if (a == 32'h00000000 && b == 32'h00000000 && op == 2'b11) return 32'h7FC00000;
    return a ^ b;
  endfunction

  assign bus.fpu_result  = fpu_model(bus.fpu_a, bus.fpu_b, bus.fpu_op);
  assign bus1.fpu_result = fpu_model(bus1.fpu_a, bus1.fpu_b, bus1.fpu_op);

  typedef struct {
    logic        owner;
    logic [31:0] result;
    logic [1:0]  exc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic mon_pop(input logic ch);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rsp_unexpected: got ch%0d result %h want no response", ch, bus.rsp_result);
    end else begin
      e = sb.pop_front();
      $display("rsp ch%0d result=%h t=%0d", ch, bus.rsp_result, cyc);
      check("rsp_owner", 32'(ch), 32'(e.owner));
      check("rsp_result", bus.rsp_result, e.result);
`ifdef FPU_ARB_EXC_EN
      check("rsp_exc", 32'(bus.rsp_exc), 32'(e.exc));
`endif
    end
  endtask

  // Response monitor: every completed handshake is matched against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        total++;
        bad++;
        $display("FAIL rsp_onehot: got both valid want one");
      end
      if (bus.rsp0_valid && bus.rsp0_ready) mon_pop(1'b0);
      if (bus.rsp1_valid && bus.rsp1_ready) mon_pop(1'b1);
    end
  end

  task automatic wait_ready(input logic ch, output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if ((ch == 1'b0 && bus.req0_ready) || (ch == 1'b1 && bus.req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 60 && sb.size() != 0; w++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic issue(input logic ch, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] res, input logic [1:0] exc);
    bit ok;
    @(posedge clk); #1;
    if (ch) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end
    wait_ready(ch, ok);
    check("issue_accept", 32'(ok), 32'd1);
    if (ok) sb.push_back(exp_t'{ch, res, exc});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    bit   ok;
    logic got;
    int   n0, n1, k;
    int   acc[3];
    int   rsp[3];
    int   na, nr;

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_op = 0;
    bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_op = 0;
    bus1.rsp0_ready = 1; bus1.rsp1_ready = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check("rst_fpu_a", bus.fpu_a, 32'd0);
    check("rst_fpu_op", 32'(bus.fpu_op), 32'd0);
    check("rst_result", bus.rsp_result, 32'd0);
    rst_n = 1'b1;

    // Both requesters continuously valid: grants alternate starting at 0
    @(posedge clk); #1;
    bus.req0_a = 32'h40400000; bus.req0_b = 32'h40000000; bus.req0_op = 2'b10;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h40000000; bus.req1_op = 2'b00;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int w = 0; w < 50; w++) begin
        @(negedge clk);
        if (bus.req0_ready || bus.req1_ready) begin ok = 1'b1; break; end
      end
      check("alt_wait", 32'(ok), 32'd1);
      if (!ok) break;
      got = bus.req1_ready;
      check("alt_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      check("alt_grant", 32'(got), 32'(i % 2));
      if (got) sb.push_back(exp_t'{1'b1, 32'h40800000, 2'b00});
      else     sb.push_back(exp_t'{1'b0, 32'h40C00000, 2'b00});
      @(posedge clk); #1;
      if (got) begin n1++; if (n1 == 2) bus.req1_valid = 1'b0; end
      else     begin n0++; if (n0 == 2) bus.req0_valid = 1'b0; end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    // Single add: latency, busy window and held operands
    @(posedge clk); #1;
    bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000; bus.req0_op = 2'b00;
    bus.req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    check("add_accept", 32'(ok), 32'd1);
    sb.push_back(exp_t'{1'b0, 32'h40400000, 2'b00});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req0_a = 32'h12345678;
    @(negedge clk);
    check("add_busy_t1", 32'(bus.busy), 32'd1);
    check("add_fpu_a", bus.fpu_a, 32'h3F800000);
    check("add_fpu_b", bus.fpu_b, 32'h40000000);
    check("add_fpu_op", 32'(bus.fpu_op), 32'd0);
    check("add_rsp_early", 32'(bus.rsp0_valid), 32'd0);
    k = 1;
    while (k < 20) begin
      @(negedge clk);
      k++;
      check("add_rsp1_quiet", 32'(bus.rsp1_valid), 32'd0);
      if (bus.rsp0_valid) break;
    end
    check("add_latency", 32'(k), 32'd3);
    check("add_busy_t3", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("add_idle_after", 32'(bus.busy), 32'd0);
    check("add_fpu_a_kept", bus.fpu_a, 32'h3F800000);
    drain();

    // Response backpressure stalls the arbiter
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000; bus.req0_op = 2'b00;
    bus.req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    check("bp_accept", 32'(ok), 32'd1);
    sb.push_back(exp_t'{1'b0, 32'h40400000, 2'b00});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_a = 32'h3F800000; bus.req1_b = 32'h3F800000; bus.req1_op = 2'b01;
    bus.req1_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.rsp0_valid) begin ok = 1'b1; break; end
    end
    check("bp_rsp_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_result_hold", bus.rsp_result, 32'h40400000);
      check("bp_rsp_valid_hold", 32'(bus.rsp0_valid), 32'd1);
      check("bp_req1_blocked", 32'(bus.req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_no_accept", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    check("bp_req1_next_idle", 32'(bus.req1_ready), 32'd1);
    if (bus.req1_ready) sb.push_back(exp_t'{1'b1, 32'h00000000, 2'b00});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    // Reset during ISSUE discards the op and restores last_grant
    @(posedge clk); #1;
    bus.req0_a = 32'h40400000; bus.req0_b = 32'h40000000; bus.req0_op = 2'b10;
    bus.req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    check("rst_mid_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_fpu_a", bus.fpu_a, 32'd0);
    check("rst_mid_fpu_b", bus.fpu_b, 32'd0);
    check("rst_mid_fpu_op", 32'(bus.fpu_op), 32'd0);
    check("rst_mid_result", bus.rsp_result, 32'd0);
    check("rst_mid_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    end
    @(posedge clk); #1;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h40000000; bus.req1_op = 2'b00;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rst_tie_req0", 32'(bus.req0_ready), 32'd1);
    check("rst_tie_req1", 32'(bus.req1_ready), 32'd0);
    if (bus.req0_ready) sb.push_back(exp_t'{1'b0, 32'h40C00000, 2'b00});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_ready(1'b1, ok);
    check("rst_req1_after", 32'(ok), 32'd1);
    if (ok) sb.push_back(exp_t'{1'b1, 32'h40800000, 2'b00});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    // SETTLE_CYCLES=1 instance: latency 2, back-to-back issue every 3 cycles
    @(posedge clk); #1;
    bus1.req0_a = 32'h3F800000; bus1.req0_b = 32'h40000000; bus1.req0_op = 2'b00;
    bus1.req0_valid = 1'b1;
    na = 0; nr = 0;
    for (int w = 0; w < 40 && (na < 3 || nr < 3); w++) begin
      @(negedge clk);
      if (bus1.req0_ready && na < 3) begin acc[na] = cyc; na++; end
      if (bus1.rsp0_valid && nr < 3) begin
        rsp[nr] = cyc; nr++;
        $display("rsp s1 ch0 result=%h t=%0d", bus1.rsp_result, cyc);
        check("s1_result", bus1.rsp_result, 32'h40400000);
      end
    end
    bus1.req0_valid = 1'b0;
    check("s1_accepts", 32'(na), 32'd3);
    check("s1_rsps", 32'(nr), 32'd3);
    if (na == 3 && nr == 3) begin
      check("s1_interval0", 32'(acc[1] - acc[0]), 32'd3);
      check("s1_interval1", 32'(acc[2] - acc[1]), 32'd3);
      for (int i = 0; i < 3; i++) check("s1_latency", 32'(rsp[i] - acc[i]), 32'd2);
    end
    repeat (4) @(negedge clk);

`ifdef FPU_ARB_EXC_EN
    issue(1'b1, 32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000, 2'b10);
    issue(1'b0, 32'h00000000, 32'h00000000, 2'b11, 32'h7FC00000, 2'b01);
`endif

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
